frame_draw_scheduler: RTL and testbench

//  Per-frame sequencer and VGA write-port arbiter for the game objects (platform, ball, bricks).
//  On each frame tick it runs each client in a fixed order:
//   1. erase every enabled client in ERASE_COLOUR;
//   2. pulse one move enable to all clients;
//   3. redraw every enabled client in its own colour.

---
 rtl/frame_draw_scheduler.sv | 173 +++++++++++++++++
 tb/tb_frame_draw_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_draw_scheduler.sv
// Per-frame sequencer: erase every enabled client, broadcast one move enable, redraw
// every enabled client, while arbitrating the single VGA write port between them.
module frame_draw_scheduler #(
  parameter int unsigned N_CLIENTS    = 3,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [N_CLIENTS-1:0]    client_mask,
  input  logic [10*N_CLIENTS-1:0] client_x,
  input  logic [10*N_CLIENTS-1:0] client_y,
  input  logic [3*N_CLIENTS-1:0]  client_col,
  input  logic [N_CLIENTS-1:0]    client_we,
  input  logic [N_CLIENTS-1:0]    client_done,
  output logic [N_CLIENTS-1:0]    client_draw,
  output logic                    move_en,
  output logic [9:0]              vga_x,
  output logic [9:0]              vga_y,
  output logic [2:0]              vga_colour,
  output logic                    vga_we,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);
  localparam int unsigned IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned WD_W  = 10;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, E_START, E_WAIT, MOVE, D_START, D_WAIT
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [N_CLIENTS-1:0] mask_q;
  logic [WD_W-1:0]      wdog;

  logic                 tick_ok, low_ok, nxt_ok;
  logic [IDX_W-1:0]     tick_idx, low_idx, nxt_idx;
  logic                 done_sel, wd_hit, active;

  function automatic logic [N_CLIENTS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Lowest enabled client (fresh mask and latched mask) and next enabled above idx.
  always_comb begin
    tick_ok  = 1'b0;
    tick_idx = '0;
    low_ok   = 1'b0;
    low_idx  = '0;
    nxt_ok   = 1'b0;
    nxt_idx  = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (client_mask[i]) begin
        tick_ok  = 1'b1;
        tick_idx = IDX_W'(i);
      end
      if (mask_q[i]) begin
        low_ok  = 1'b1;
        low_idx = IDX_W'(i);
      end
      if (mask_q[i] && (i > int'(idx))) begin
        nxt_ok  = 1'b1;
        nxt_idx = IDX_W'(i);
      end
    end
  end

  assign done_sel = client_done[idx];
  assign wd_hit   = (wdog == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      mask_q      <= '0;
      wdog        <= '0;
      client_draw <= '0;
      move_en     <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      client_draw <= '0;
      move_en     <= 1'b0;
      if (frame_tick && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            mask_q <= client_mask;
            busy   <= 1'b1;
            if (tick_ok) begin
              state       <= E_START;
              idx         <= tick_idx;
              client_draw <= onehot(tick_idx);
              wdog        <= '0;
            end else begin
              state   <= MOVE;
              move_en <= 1'b1;
            end
          end
        end
        E_START: state <= E_WAIT;
        E_WAIT: begin
          if (done_sel || wd_hit) begin
            if (!done_sel) timeout_err <= 1'b1;
            if (nxt_ok) begin
              state       <= E_START;
              idx         <= nxt_idx;
              client_draw <= onehot(nxt_idx);
              wdog        <= '0;
            end else begin
              state   <= MOVE;
              move_en <= 1'b1;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        MOVE: begin
          if (low_ok) begin
            state       <= D_START;
            idx         <= low_idx;
            client_draw <= onehot(low_idx);
            wdog        <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        D_START: state <= D_WAIT;
        D_WAIT: begin
          if (done_sel || wd_hit) begin
            if (!done_sel) timeout_err <= 1'b1;
            if (nxt_ok) begin
              state       <= D_START;
              idx         <= nxt_idx;
              client_draw <= onehot(nxt_idx);
              wdog        <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the selected client reaches the VGA port, and only while it owns a pass slot.
  always_comb begin
    active     = (state == E_START) || (state == E_WAIT) ||
                 (state == D_START) || (state == D_WAIT);
    vga_x      = '0;
    vga_y      = '0;
    vga_we     = 1'b0;
    vga_colour = '0;
    if (active) begin
      vga_x      = client_x[10*idx +: 10];
      vga_y      = client_y[10*idx +: 10];
      vga_we     = client_we[idx];
      vga_colour = ((state == E_START) || (state == E_WAIT)) ? ERASE_COLOUR
                                                              : client_col[3*idx +: 3];
    end
  end
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Randomized bench for frame_draw_scheduler: a per-pass timeline model predicts every
// cycle's draw/move/busy/flag outputs and which client owns the VGA port.
module tb_frame_draw_scheduler;
  localparam int MAXC = 512;
  localparam int T_MAIN = 1023;
  localparam int T_SHORT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [2:0]  client_mask = '0;
  logic [29:0] client_x = '0;
  logic [29:0] client_y = '0;
  logic [8:0]  client_col = '0;
  logic [2:0]  client_we = '0;
  logic [2:0]  client_done = '0;

  logic [2:0] m_draw, t_draw, o_draw;
  logic       m_move, t_move, o_move;
  logic [9:0] m_vx, t_vx, o_vx, m_vy, t_vy, o_vy;
  logic [2:0] m_vc, t_vc, o_vc;
  logic       m_vwe, t_vwe, o_vwe, m_busy, t_busy, o_busy;
  logic       m_ovr, t_ovr, o_ovr, m_to, t_to, o_to;

  bit use_to = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  bit exp_ovr = 1'b0;
  bit exp_to = 1'b0;

  // Timeline model of one pass, indexed by cycles after the tick cycle (0).
  int exp_draw_idx[MAXC];
  bit exp_move[MAXC];
  int sel_idx[MAXC];
  int sel_ph[MAXC];
  int done_at[MAXC];
  int to_at;
  int len;
  int ke[3];
  int kd[3];

  frame_draw_scheduler #(.N_CLIENTS(3), .ERASE_COLOUR(3'b000), .TIMEOUT(T_MAIN)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .client_mask(client_mask),
    .client_x(client_x), .client_y(client_y), .client_col(client_col),
    .client_we(client_we), .client_done(client_done), .client_draw(m_draw),
    .move_en(m_move), .vga_x(m_vx), .vga_y(m_vy), .vga_colour(m_vc), .vga_we(m_vwe),
    .busy(m_busy), .overrun(m_ovr), .timeout_err(m_to));

  frame_draw_scheduler #(.N_CLIENTS(3), .ERASE_COLOUR(3'b000), .TIMEOUT(T_SHORT)) dut_to (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .client_mask(client_mask),
    .client_x(client_x), .client_y(client_y), .client_col(client_col),
    .client_we(client_we), .client_done(client_done), .client_draw(t_draw),
    .move_en(t_move), .vga_x(t_vx), .vga_y(t_vy), .vga_colour(t_vc), .vga_we(t_vwe),
    .busy(t_busy), .overrun(t_ovr), .timeout_err(t_to));

  assign o_draw = use_to ? t_draw : m_draw;
  assign o_move = use_to ? t_move : m_move;
  assign o_vx   = use_to ? t_vx   : m_vx;
  assign o_vy   = use_to ? t_vy   : m_vy;
  assign o_vc   = use_to ? t_vc   : m_vc;
  assign o_vwe  = use_to ? t_vwe  : m_vwe;
  assign o_busy = use_to ? t_busy : m_busy;
  assign o_ovr  = use_to ? t_ovr  : m_ovr;
  assign o_to   = use_to ? t_to   : m_to;

  always #5 clk = ~clk;

  // Erase pass, move, draw pass; a client occupies START plus min(delay, T) WAIT cycles.
  task automatic build(input bit [2:0] m, input int t);
    int c, k, e;
    for (int r = 0; r < MAXC; r++) begin
      exp_draw_idx[r] = -1; exp_move[r] = 1'b0;
      sel_idx[r] = 0; sel_ph[r] = 0; done_at[r] = -1;
    end
    c = 1;
    to_at = -1;
    for (int ph = 1; ph <= 2; ph++) begin
      if (ph == 2) begin
        exp_move[c] = 1'b1;
        c++;
      end
      for (int i = 0; i < 3; i++) begin
        if (m[i]) begin
          k = (ph == 1) ? ke[i] : kd[i];
          e = (k < t) ? k : t;
          exp_draw_idx[c] = i;
          for (int j = 0; j <= e; j++) begin
            sel_idx[c+j] = i;
            sel_ph[c+j] = ph;
          end
          if (k <= t) done_at[c+k] = i;
          else if (to_at < 0) to_at = c + t + 1;
          c = c + e + 1;
        end
      end
    end
    len = c;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    client_done = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    exp_ovr = 1'b0;
    exp_to = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs one pass cycle by cycle against the model; optionally resets mid draw pass.
  task automatic drive_pass(input bit [2:0] m, input bit extra_req, input bit force_we0,
                            input bit abort);
    int t, wi, ci;
    bit extra;
    logic [2:0] d, exp_d, exp_c;
    t = use_to ? T_SHORT : T_MAIN;
    build(m, t);
    if (len + 3 >= MAXC) begin
      $display("FAIL pass_length len=%0d limit=%0d", len, MAXC);
      $fatal(1);
    end
    extra = extra_req && (len > 6);
    for (int r = 0; r <= len + 2; r++) begin
      frame_tick = (r == 0) || (extra && r == 5);
      client_mask = (r == 0) ? m : 3'($urandom);
      client_x = 30'($urandom);
      client_y = 30'($urandom);
      client_col = 9'($urandom);
      client_we = 3'($urandom);
      if (force_we0) client_we[0] = 1'b1;
      wi = (sel_ph[r] != 0 && exp_draw_idx[r] < 0) ? sel_idx[r] : -1;
      d = 3'($urandom);
      if (wi >= 0) d[wi] = (done_at[r] == wi);
      client_done = d;
      #1;
      if (extra && r == 6) exp_ovr = 1'b1;
      if (to_at >= 0 && r == to_at) exp_to = 1'b1;
      exp_d = (exp_draw_idx[r] >= 0) ? (3'b001 << exp_draw_idx[r]) : 3'b000;
      n_cmp++;
      if (o_draw !== exp_d) begin
        n_bad++; $display("FAIL client_draw r=%0d got %b want %b", r, o_draw, exp_d);
      end
      n_cmp++;
      if (o_move !== exp_move[r]) begin
        n_bad++; $display("FAIL move_en r=%0d got %b want %b", r, o_move, exp_move[r]);
      end
      n_cmp++;
      if (o_busy !== (r >= 1 && r < len)) begin
        n_bad++; $display("FAIL busy r=%0d got %b len=%0d", r, o_busy, len);
      end
      n_cmp++;
      if (o_ovr !== exp_ovr) begin
        n_bad++; $display("FAIL overrun r=%0d got %b want %b", r, o_ovr, exp_ovr);
      end
      n_cmp++;
      if (o_to !== exp_to) begin
        n_bad++; $display("FAIL timeout_err r=%0d got %b want %b", r, o_to, exp_to);
      end
      if (sel_ph[r] != 0) begin
        ci = sel_idx[r];
        exp_c = (sel_ph[r] == 1) ? 3'b000 : client_col[3*ci +: 3];
        n_cmp++;
        if (o_vwe !== client_we[ci] || o_vc !== exp_c ||
            o_vx !== client_x[10*ci +: 10] || o_vy !== client_y[10*ci +: 10]) begin
          n_bad++;
          $display("FAIL vga_mux r=%0d got we=%b col=%b x=%0d y=%0d want client %0d we=%b col=%b x=%0d y=%0d",
                   r, o_vwe, o_vc, o_vx, o_vy, ci, client_we[ci], exp_c,
                   client_x[10*ci +: 10], client_y[10*ci +: 10]);
        end
      end else begin
        n_cmp++;
        if (o_vwe !== 1'b0 || o_vc !== 3'b000) begin
          n_bad++; $display("FAIL vga_idle r=%0d got we=%b col=%b want 0/000", r, o_vwe, o_vc);
        end
      end
      if (abort && sel_ph[r] == 2 && exp_draw_idx[r] < 0 && sel_idx[r] == 1) begin
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({o_draw, o_move, o_busy, o_ovr, o_to, o_vwe, o_vc} !== 11'b0) begin
          n_bad++;
          $display("FAIL reset_mid_pass got draw=%b move=%b busy=%b ovr=%b to=%b we=%b col=%b want all 0",
                   o_draw, o_move, o_busy, o_ovr, o_to, o_vwe, o_vc);
        end
        #2 reset = 1'b0;
        exp_ovr = 1'b0;
        exp_to = 1'b0;
        for (int q = 0; q < 4; q++) begin
          @(posedge clk);
          #1;
          client_done = 3'($urandom);
          #1;
          n_cmp++;
          if (o_draw !== 3'b000 || o_move !== 1'b0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset q=%0d got draw=%b move=%b busy=%b want 0", q, o_draw, o_move, o_busy);
          end
        end
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_delays(input int e0, input int e1, input int e2,
                            input int d0, input int d1, input int d2);
    ke[0] = e0; ke[1] = e1; ke[2] = e2;
    kd[0] = d0; kd[1] = d1; kd[2] = d2;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({o_draw, o_move, o_busy, o_ovr, o_to, o_vwe, o_vc} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_state got draw=%b move=%b busy=%b ovr=%b to=%b we=%b col=%b want all 0",
               o_draw, o_move, o_busy, o_ovr, o_to, o_vwe, o_vc);
    end
  endtask

  task automatic test_full_mask();
    set_delays(20, 20, 20, 20, 20, 20);
    drive_pass(3'b111, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sparse_mask();
    set_delays(4, 9, 7, 2, 9, 11);
    drive_pass(3'b101, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_empty_mask();
    set_delays(1, 1, 1, 1, 1, 1);
    drive_pass(3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    set_delays(3, 3, 3, 3, 3, 3);
    drive_pass(3'b111, 1'b1, 1'b0, 1'b0);
    drive_pass(3'b011, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_we_isolation();
    set_delays(5, 12, 5, 5, 12, 5);
    drive_pass(3'b010, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      set_delays($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12),
                 $urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12));
      drive_pass(3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_timeout();
    use_to = 1'b1;
    do_reset();
    set_delays(4, 1000, 6, 3, 5, 2);
    drive_pass(3'b111, 1'b0, 1'b0, 1'b0);
    set_delays(2, 2, 2, 2, 2, 2);
    drive_pass(3'b110, 1'b0, 1'b0, 1'b0);
    use_to = 1'b0;
  endtask

  task automatic test_reset_mid_pass();
    do_reset();
    set_delays(5, 6, 5, 5, 8, 5);
    drive_pass(3'b111, 1'b0, 1'b0, 1'b1);
    set_delays(3, 4, 5, 6, 7, 8);
    drive_pass(3'b111, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_empty_mask();
    test_overrun();
    test_we_isolation();
    test_random();
    test_timeout();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
